period_meter: RTL and testbench
===============================

# period_meter

Measures the half-period of a slow toggling signal, such as a divided clock, in `clock_in` cycles, and reports each measurement with a one-cycle valid pulse. It is the receiving end of our clock-divider outputs and is used to check divided clocks and external slow strobes against their expected rates. It also flags loss of activity on the signal.

## Interface
- `COUNT_WIDTH`, 23: width of the cycle counter and of the `half_period` output.
- `TIMEOUT_CYCLES`, 4_000_000: cycles without an edge before timeout. Must be ≥2 and ≤ 2^COUNT_WIDTH−1.
- `STABLE_COUNT`, 4: consecutive equal measurements required for lock. Used only with `PERIOD_METER_STABILITY_EN`; must be ≥1.
- `clock_in`, input, 1: system clock.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `signal_in`, input, 1: monitored signal, asynchronous to `clock_in`.
- `clear`, input, 1: synchronous restart of measurement.
- `half_period`, output, COUNT_WIDTH: last measured number of cycles between consecutive edges.
- `valid`, output, 1: one-cycle pulse when `half_period` updates.
- `locked`, output, 1: measurement considered stable.
- `timeout`, output, 1: sticky flag indicating no edge within `TIMEOUT_CYCLES`.

## Operation
- `signal_in` passes through a 2-flop synchronizer, then a registered edge detector. Rising and falling edges both count as edges.
- **States**
  - WAIT_EDGE: entered on reset, on `clear`, or after a timeout. No measurement is possible until the first edge.
  - MEASURE: counting cycles since the last edge.
- **Transitions**
  - WAIT_EDGE + edge → MEASURE, counter ← 1, no `valid`.
  - MEASURE + edge → `half_period` ← counter, `valid` = 1, counter ← 1, stay in MEASURE.
  - MEASURE, no edge → counter +1.
  - MEASURE with counter == TIMEOUT_CYCLES and no edge → WAIT_EDGE, `timeout` ← 1, `locked` ← 0, counter ← 0.
- **Arithmetic:** the counter is unsigned, COUNT_WIDTH bits, and never wraps, because timeout fires before overflow. A signal toggling every N cycles therefore measures exactly N.
- **Simultaneous events**
  - `clear` beats an edge: state → WAIT_EDGE, counter ← 0, `locked` ← 0, `timeout` ← 0, `half_period` is held.
  - An edge beats a timeout in the same cycle: the measurement completes normally.
- `timeout` is sticky. It is cleared only by `clear` or reset; a new edge alone does not clear it.
- Reset asserted mid-measurement aborts the measurement with no `valid` pulse.
- **Reset values:** `half_period`=0, `valid`=0, `locked`=0, `timeout`=0, state = WAIT_EDGE, counter = 0, synchronizer flops = 0.

## Timing
- Latency from a `signal_in` transition to `valid` is 3 `clock_in` cycles: 2 cycles of synchronizer plus 1 of edge register.
- `valid` and `half_period` change on the same clock edge. `half_period` is stable until the next `valid`.
- `locked` and `timeout` update on the same edge as the event that causes them.
- The minimum measurable half-period is 2 cycles. Faster toggling yields undefined values, but no hang.

## Configuration
- **`PERIOD_METER_STABILITY_EN` defined**
  - `locked` asserts on the `valid` that completes `STABLE_COUNT` consecutive identical measurements.
  - Any differing measurement drops `locked` and restarts the match count at 1.
- **Macro undefined**
  - `locked` asserts on the first `valid` after WAIT_EDGE.
  - `locked` drops only on timeout, `clear`, or reset.
  - `STABLE_COUNT` is ignored, and no previous-value register is built.

## Structure
- **Package `period_meter_pkg`**
  - state enum: `PM_WAIT_EDGE`, `PM_MEASURE`.
  - default constants for `COUNT_WIDTH`, `TIMEOUT_CYCLES`, `STABLE_COUNT`.
- **Sub-module `sync_edge_detect`**
  - Contains the 2-flop synchronizer and edge register.
  - Outputs a single-cycle `edge` pulse.
  - Reset with the same `reset_n`.
  - Reusable for other asynchronous inputs.

## Test plan
- **Divider check:** drive `signal_in` from a clock divider with half-divide 5 → first `valid` arrives 3 cycles after the second toggle with `half_period`=5, and every subsequent `valid` also reports 5.
- **Stability lock (macro defined, `STABLE_COUNT`=4):** 5,5,5,5 → `locked` rises on the 4th `valid`. A following 6 → `locked`=0; four more 6s → `locked`=1.
- **Timeout (`TIMEOUT_CYCLES`=20):** hold `signal_in` constant → `timeout`=1 and `locked`=0 exactly 20 cycles after the last edge is counted, and no `valid`. The next two edges produce a `valid`, and `timeout` stays 1 until `clear`.
- **Clear/edge collision:** pulse `clear` in the same cycle as a detected edge → no `valid`, state WAIT_EDGE, `half_period` unchanged. The first `valid` comes only after two further edges.
- **Reset mid-measure:** assert `reset_n`=0 while the counter is 7 → all outputs return to 0 immediately. After release, the first edge produces no `valid`.
- **Edge on the timeout cycle:** place an edge exactly at counter == TIMEOUT_CYCLES → `valid` with `half_period`=TIMEOUT_CYCLES, and `timeout` stays 0.

Source files
------------

// File: rtl/period_meter_pkg.sv
// Shared types and default sizing for the period meter.
package period_meter_pkg;

    typedef enum logic {
        PM_WAIT_EDGE = 1'b0,
        PM_MEASURE   = 1'b1
    } pm_state_e;

    localparam int DEFAULT_COUNT_WIDTH    = 23;
    localparam int DEFAULT_TIMEOUT_CYCLES = 4_000_000;
    localparam int DEFAULT_STABLE_COUNT   = 4;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus a registered copy; pulses edge_pulse for one cycle
// on either transition of async_in. Reusable for any asynchronous level input.
module sync_edge_detect (
    input  logic clock_in,
    input  logic reset_n,
    input  logic async_in,
    output logic edge_pulse
);

    logic meta;
    logic sync;
    logic last;

    // NOTE: non-blocking assignments so all three flops shift together as a pipeline.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            last <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            last <= sync;
        end
    end

    assign edge_pulse = sync ^ last;

endmodule

// File: rtl/period_meter.sv
// Half-period meter for a slow toggling signal, with activity timeout and lock flag.
// Define PERIOD_METER_STABILITY_EN to require STABLE_COUNT equal measurements for lock.
module period_meter
    import period_meter_pkg::*;
#(
    parameter int COUNT_WIDTH    = DEFAULT_COUNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int STABLE_COUNT   = DEFAULT_STABLE_COUNT
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    input  logic                   signal_in,
    input  logic                   clear,
    output logic [COUNT_WIDTH-1:0] half_period,
    output logic                   valid,
    output logic                   locked,
    output logic                   timeout
);

    if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES >> COUNT_WIDTH) != 0 || STABLE_COUNT < 1)
    begin : g_bad_params
        $error("period_meter: parameter out of range");
    end

    localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LIMIT = COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE     = COUNT_WIDTH'(1);

    pm_state_e              state, state_next;
    logic [COUNT_WIDTH-1:0] count, count_next;
    logic [COUNT_WIDTH-1:0] half_period_next;
    logic                   valid_next, locked_next, timeout_next;
    logic                   edge_pulse;

`ifdef PERIOD_METER_STABILITY_EN
    localparam int                    MATCH_WIDTH  = $clog2(STABLE_COUNT + 1);
    localparam logic [MATCH_WIDTH-1:0] MATCH_TARGET = MATCH_WIDTH'(STABLE_COUNT);
    logic [MATCH_WIDTH-1:0] match_count, match_next;
`endif

    sync_edge_detect u_sync_edge_detect (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .async_in   (signal_in),
        .edge_pulse (edge_pulse)
    );

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PM_WAIT_EDGE;
            count       <= '0;
            half_period <= '0;
            valid       <= 1'b0;
            locked      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_next;
            count       <= count_next;
            half_period <= half_period_next;
            valid       <= valid_next;
            locked      <= locked_next;
            timeout     <= timeout_next;
        end
    end

`ifdef PERIOD_METER_STABILITY_EN
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) match_count <= '0;
        else          match_count <= match_next;
    end
`endif

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_next       = state;
        count_next       = count;
        half_period_next = half_period;
        valid_next       = 1'b0;
        locked_next      = locked;
        timeout_next     = timeout;
`ifdef PERIOD_METER_STABILITY_EN
        match_next       = match_count;
`endif
        // Clear outranks any edge or timeout arriving in the same cycle.
        if (clear) begin
            state_next   = PM_WAIT_EDGE;
            count_next   = '0;
            locked_next  = 1'b0;
            timeout_next = 1'b0;
`ifdef PERIOD_METER_STABILITY_EN
            match_next   = '0;
`endif
        end else begin
            unique case (state)
                PM_WAIT_EDGE: begin
                    if (edge_pulse) begin
                        state_next = PM_MEASURE;
                        count_next = COUNT_ONE;
                    end
                end
                PM_MEASURE: begin
                    if (edge_pulse) begin
                        half_period_next = count;
                        valid_next       = 1'b1;
                        count_next       = COUNT_ONE;
`ifdef PERIOD_METER_STABILITY_EN
                        // half_period still holds the previous measurement here.
                        if (match_count != '0 && count == half_period)
                            match_next = (match_count == MATCH_TARGET) ? match_count
                                                                       : match_count + 1'b1;
                        else
                            match_next = MATCH_WIDTH'(1);
                        locked_next = (match_next == MATCH_TARGET);
`else
                        locked_next = 1'b1;
`endif
                    end else if (count == TIMEOUT_LIMIT) begin
                        state_next   = PM_WAIT_EDGE;
                        count_next   = '0;
                        timeout_next = 1'b1;
                        locked_next  = 1'b0;
`ifdef PERIOD_METER_STABILITY_EN
                        match_next   = '0;
`endif
                    end else begin
                        count_next = count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench for period_meter: directed scenarios plus randomized toggling,
// compared every cycle against a timestamp-based model of edges and measurements.
`timescale 1ns/1ps
module tb_period_meter;

    localparam int W  = 16;
    localparam int TO = 20;
    localparam int SC = 4;
`ifdef PERIOD_METER_STABILITY_EN
    localparam bit STAB = 1'b1;
`else
    localparam bit STAB = 1'b0;
`endif

    logic         clock_in = 1'b0;
    logic         reset_n  = 1'b1;
    logic         signal_in = 1'b0;
    logic         clear    = 1'b0;
    logic [W-1:0] half_period;
    logic         valid, locked, timeout;

    period_meter #(.COUNT_WIDTH(W), .TIMEOUT_CYCLES(TO), .STABLE_COUNT(SC)) dut (
        .clock_in    (clock_in),
        .reset_n     (reset_n),
        .signal_in   (signal_in),
        .clear       (clear),
        .half_period (half_period),
        .valid       (valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clock_in = ~clock_in;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: an input toggle becomes a detected edge three clock edges later; a
    // measurement is the distance between consecutive detected edges.
    int           due_q[$];
    int           meas_q[$];
    bit           armed;
    int           ref_cyc;
    logic         m_valid, m_locked, m_timeout;
    logic [W-1:0] m_hp;

    function automatic logic lock_rule();
        int run = 0;
        if (!STAB) return 1'b1;
        if (meas_q.size() == 0) return 1'b0;
        for (int i = meas_q.size() - 1; i >= 0 && meas_q[i] == meas_q[meas_q.size()-1]; i--)
            run++;
        return (run >= SC);
    endfunction

    task automatic model_reset();
        armed = 0; ref_cyc = 0;
        m_valid = 0; m_locked = 0; m_timeout = 0; m_hp = '0;
        due_q.delete();
        meas_q.delete();
    endtask

    task automatic model_step(input logic clr);
        bit edge_now = 0;
        if (due_q.size() != 0 && due_q[0] == cyc) begin
            edge_now = 1;
            void'(due_q.pop_front());
        end
        m_valid = 0;
        if (clr) begin
            armed = 0; m_timeout = 0; m_locked = 0; meas_q.delete();
        end else if (edge_now) begin
            if (armed) begin
                m_hp    = W'(cyc - ref_cyc);
                m_valid = 1;
                meas_q.push_back(cyc - ref_cyc);
                m_locked = lock_rule();
            end
            armed = 1; ref_cyc = cyc;
        end else if (armed && (cyc - ref_cyc) == TO) begin
            armed = 0; m_timeout = 1; m_locked = 0; meas_q.delete();
        end
    endtask

    // Drive inputs for one cycle, advance past the rising edge, update the model.
    task automatic tick(input logic tog, input logic clr);
        if (tog) begin
            signal_in = ~signal_in;
            due_q.push_back(cyc + 3);
        end
        clear = clr;
        @(posedge clock_in);
        cyc++;
        model_step(clr);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; signal_in = 1'b0; clear = 1'b0;
        model_reset();
        repeat (3) begin @(posedge clock_in); cyc++; end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (half_period !== '0) begin errors++; $display("FAIL reset_half_period got=%0d exp=0", half_period); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got=%b exp=0", locked); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        repeat (5) begin
            tick(1'b0, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
        end
    endtask

    task automatic test_divider();
        int first_valid = -1;
        int nvalid = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 62; i++) begin
            tick((i % 5) == 0, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL divider cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
            if (valid === 1'b1) begin
                nvalid++;
                if (first_valid < 0) first_valid = i;
            end
        end
        // Second toggle is driven in tick 5; three rising edges later is tick 7.
        checks++; if (first_valid != 7) begin errors++; $display("FAIL divider_first_valid got=%0d exp=7", first_valid); end
        checks++; if (nvalid != 11) begin errors++; $display("FAIL divider_valid_count got=%0d exp=11", nvalid); end
    endtask

    task automatic test_timeout();
        int first_to = -1;
        bit saw_valid = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 40; i++) begin
            tick(i == 0 || i == 6, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL timeout cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
            if (timeout === 1'b1 && first_to < 0) first_to = i;
        end
        // Last edge is seen after tick 8, so the timeout lands 20 cycles later.
        checks++; if (first_to != 28) begin errors++; $display("FAIL timeout_cycle got=%0d exp=28", first_to); end
        for (int i = 0; i < 12; i++) begin
            tick(i == 0 || i == 4, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL timeout_rearm cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
            if (valid === 1'b1) saw_valid = 1;
        end
        checks++; if (!saw_valid) begin errors++; $display("FAIL timeout_rearm_valid got=0 exp=1"); end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky got=%b exp=1", timeout); end
        tick(1'b0, 1'b1);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", timeout); end
    endtask

    task automatic test_clear_collision();
        int first_valid = -1;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            tick(i == 0 || i == 7, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL collision_setup cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
        end
        // Toggle now; clear is sampled on the same edge that detects it.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL collision_valid got=%b exp=0", valid); end
        checks++; if (half_period !== W'(7)) begin errors++; $display("FAIL collision_hold got=%0d exp=7", half_period); end
        for (int i = 0; i < 20; i++) begin
            tick(i == 0 || i == 5 || i == 10, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL collision_after cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
            if (valid === 1'b1 && first_valid < 0) first_valid = i;
        end
        checks++; if (first_valid != 7) begin errors++; $display("FAIL collision_first_valid got=%0d exp=7", first_valid); end
    endtask

    task automatic test_timeout_edge();
        bit saw20 = 0;
        bit saw_to = 0;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 26; i++) begin
            tick(i == 0 || i == TO, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL timeout_edge cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
            if (valid === 1'b1 && half_period === W'(TO)) saw20 = 1;
            if (timeout === 1'b1) saw_to = 1;
        end
        checks++; if (!saw20) begin errors++; $display("FAIL timeout_edge_measure got=0 exp=1"); end
        checks++; if (saw_to) begin errors++; $display("FAIL timeout_edge_flag got=1 exp=0"); end
    endtask

    task automatic test_reset_mid();
        int nvalid = 0;
        tick(1'b0, 1'b1);
        // Second edge seen after tick 8 (counter 1); counter reaches 7 after tick 14.
        for (int i = 0; i < 15; i++) begin
            tick(i == 0 || i == 6, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL reset_mid_setup cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({valid, half_period, locked, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_mid_async got v=%b hp=%0d lk=%b to=%b exp all 0", valid, half_period, locked, timeout);
        end
        signal_in = 1'b0;
        model_reset();
        repeat (2) begin @(posedge clock_in); cyc++; end
        #1 reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(i == 0 || i == 8, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL reset_mid_after cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
            if (valid === 1'b1) nvalid++;
        end
        checks++; if (nvalid != 1) begin errors++; $display("FAIL reset_mid_valid_count got=%0d exp=1", nvalid); end
    endtask

    task automatic test_lock();
        int gaps[9] = '{5, 5, 5, 5, 6, 6, 6, 6, 6};
        int tog_at[$];
        logic lock_at_valid[$];
        int pos = 0;
        tog_at.push_back(0);
        foreach (gaps[k]) begin pos += gaps[k]; tog_at.push_back(pos); end
        tick(1'b0, 1'b1);
        for (int i = 0; i < pos + 6; i++) begin
            bit tog = 0;
            foreach (tog_at[k]) if (tog_at[k] == i) tog = 1;
            tick(tog, 1'b0);
            checks++;
            if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                errors++;
                $display("FAIL lock cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                         cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
            end
            if (valid === 1'b1) lock_at_valid.push_back(locked);
        end
        checks++;
        if (lock_at_valid.size() != 9) begin
            errors++;
            $display("FAIL lock_valid_count got=%0d exp=9", lock_at_valid.size());
        end else begin
            checks++; if (lock_at_valid[2] !== !STAB) begin errors++; $display("FAIL lock_third got=%b exp=%b", lock_at_valid[2], !STAB); end
            checks++; if (lock_at_valid[3] !== 1'b1) begin errors++; $display("FAIL lock_fourth got=%b exp=1", lock_at_valid[3]); end
            checks++; if (lock_at_valid[4] !== !STAB) begin errors++; $display("FAIL lock_drop got=%b exp=%b", lock_at_valid[4], !STAB); end
            checks++; if (lock_at_valid[8] !== 1'b1) begin errors++; $display("FAIL lock_relock got=%b exp=1", lock_at_valid[8]); end
        end
    endtask

    task automatic test_random();
        tick(1'b0, 1'b1);
        for (int s = 0; s < 60; s++) begin
            int n = $urandom_range(2, 24);
            for (int j = 1; j <= n; j++) begin
                tick(j == n, $urandom_range(0, 49) == 0);
                checks++;
                if (valid !== m_valid || half_period !== m_hp || locked !== m_locked || timeout !== m_timeout) begin
                    errors++;
                    $display("FAIL random cyc=%0d got v=%b hp=%0d lk=%b to=%b exp v=%b hp=%0d lk=%b to=%b",
                             cyc, valid, half_period, locked, timeout, m_valid, m_hp, m_locked, m_timeout);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_timeout();
        test_clear_collision();
        test_timeout_edge();
        test_reset_mid();
        test_lock();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
